// File: rtl/flash_cmd_pkg.sv
// Shared constants for the UART flash command front-end: framing characters,
// opcodes, status codes and opcode classification helpers.
package flash_cmd_pkg;

  localparam logic [7:0] CH_TILDE = 8'h7E;
  localparam logic [7:0] CH_ONE   = 8'h31;
  localparam logic [7:0] CH_UNDER = 8'h5F;
  localparam logic [7:0] CH_ACK   = 8'h61;  // 'a'
  localparam logic [7:0] CH_DATA  = 8'h6B;  // 'k'
  localparam logic [7:0] CH_FULL  = 8'h66;  // 'f'
  localparam logic [7:0] CH_CR    = 8'h0D;

  localparam logic [7:0] OP_CHIP_ERASE   = 8'hC7;
  localparam logic [7:0] OP_PAGE_ERASE   = 8'h81;
  localparam logic [7:0] OP_ARRAY_READ   = 8'hE8;
  localparam logic [7:0] OP_BUF1_TO_PAGE = 8'h83;
  localparam logic [7:0] OP_BUF2_TO_PAGE = 8'h86;
  localparam logic [7:0] OP_BUF1_WRITE   = 8'h84;
  localparam logic [7:0] OP_BUF2_WRITE   = 8'h87;
  localparam logic [7:0] OP_PROG_BUF1    = 8'h82;
  localparam logic [7:0] OP_PROG_BUF2    = 8'h85;
  localparam logic [7:0] OP_READ_ID      = 8'h9F;
  localparam logic [7:0] OP_READ_STATUS  = 8'hD7;
  localparam logic [7:0] OP_BUF1_READ    = 8'hD4;
  localparam logic [7:0] OP_BUF2_READ    = 8'hD6;

  typedef enum logic [7:0] {
    ST_OK      = 8'h00,
    ST_CRC     = 8'h01,
    ST_UNKNOWN = 8'h02,
    ST_TIMEOUT = 8'h03,
    ST_BUSY    = 8'h04
  } status_t;

  typedef enum logic [1:0] {
    RESP_STATUS,
    RESP_DATA,
    RESP_BFF
  } resp_kind_t;

  function automatic logic is_acked(input logic [7:0] op);
    case (op)
      OP_CHIP_ERASE, OP_PAGE_ERASE, OP_ARRAY_READ, OP_BUF1_TO_PAGE,
      OP_BUF2_TO_PAGE, OP_BUF1_WRITE, OP_BUF2_WRITE, OP_PROG_BUF1,
      OP_PROG_BUF2: is_acked = 1'b1;
      default:      is_acked = 1'b0;
    endcase
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    case (op)
      OP_READ_ID, OP_READ_STATUS, OP_BUF1_READ, OP_BUF2_READ: is_known = 1'b1;
      default: is_known = is_acked(op);
    endcase
  endfunction

endpackage

// File: rtl/uart_resp_serializer.sv
// Serialises one response frame (status, read data or buffer-full) into a
// byte-level UART transmitter, pacing each byte on tx_busy.
module uart_resp_serializer
  import flash_cmd_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  localparam int PAY_W = (DATA_BYTES >= 2) ? 8 * DATA_BYTES : 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  resp_kind_t       kind,
  input  logic [PAY_W-1:0] payload,
  output logic             busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy
);

  localparam int LEN   = (DATA_BYTES + 4 > 6) ? DATA_BYTES + 4 : 6;
  localparam int SR_W  = 8 * LEN;
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_START, S_GAP} sstate_t;

  sstate_t          state_reg, state_next;
  logic [SR_W-1:0]  sr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_start_reg;
  logic [SR_W-1:0]  frame;
  logic [CNT_W-1:0] frame_len;

  // Frames are left-aligned so the next byte is always the top of sr_reg.
  always_comb begin
    frame     = '0;
    frame_len = '0;
    case (kind)
      RESP_STATUS: begin
        frame[SR_W-1 -: 48] = {CH_TILDE, CH_ACK, CH_UNDER, payload[15:0], CH_CR};
        frame_len = CNT_W'(6);
      end
      RESP_DATA: begin
        frame[SR_W-1 -: 8*(DATA_BYTES+4)] =
          {CH_TILDE, CH_DATA, CH_UNDER, payload[8*DATA_BYTES-1:0], CH_CR};
        frame_len = CNT_W'(DATA_BYTES + 4);
      end
      RESP_BFF: begin
        frame[SR_W-1 -: 32] = {CH_TILDE, CH_FULL, CH_UNDER, CH_CR};
        frame_len = CNT_W'(4);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // S_GAP skips the cycle where the transmitter may not yet show busy.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (load) state_next = S_WAIT;
      S_WAIT:  if (!tx_busy) state_next = S_START;
      S_START: state_next = (cnt_reg == '0) ? S_IDLE : S_GAP;
      S_GAP:   state_next = S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg       <= '0;
      cnt_reg      <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      if (state_reg == S_IDLE && load) begin
        sr_reg  <= frame;
        cnt_reg <= frame_len;
      end else if (state_reg == S_WAIT && !tx_busy) begin
        tx_data_reg  <= sr_reg[SR_W-1 -: 8];
        tx_start_reg <= 1'b1;
        sr_reg       <= sr_reg << 8;
        cnt_reg      <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign busy     = (state_reg != S_IDLE);
  assign tx_data  = tx_data_reg;
  assign tx_start = tx_start_reg;

endmodule

// File: rtl/flash_uart_cmd_ctrl.sv
// UART command front-end: parses checksummed command frames into a flash
// command handshake and queues status, read-data and buffer-full responses.
module flash_uart_cmd_ctrl
  import flash_cmd_pkg::*;
#(
  parameter int ADR_BYTES    = 3,
  parameter int DATA_BYTES   = 4,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_op,
  output logic [8*ADR_BYTES-1:0]  cmd_adr,
  input  logic                    rd_valid,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  input  logic                    bff,
  output logic                    pause,
  output logic                    overrun
);

  localparam int ADR_W  = 8 * ADR_BYTES;
  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int PAY_W  = (DATA_BYTES >= 2) ? DATA_W : 16;
  localparam int IDX_W  = $clog2(ADR_BYTES + 2);
  localparam int TMO_W  = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} pstate_t;

  pstate_t          pstate_reg, pstate_next;
  logic [23:0]      hdr_sr_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       sum_reg, op_reg;
  logic [ADR_W-1:0] adr_reg;
  logic             csum_ok_reg;
  logic [TMO_W-1:0] tmo_reg;

  logic             cmd_valid_reg;
  logic [7:0]       cmd_op_reg;
  logic [ADR_W-1:0] cmd_adr_reg;

  logic             st_pend_reg, data_pend_reg, bff_pend_reg, overrun_reg;
  status_t          st_code_reg;
  logic [7:0]       st_op_reg;
  logic [DATA_W-1:0] data_reg;

  logic [23:0] hdr_shift;
  logic        hdr_hit, last_byte, tmo_hit, chk_run, chk_accept, handshake;
  logic        st_set;
  status_t     st_code_next;
  logic [7:0]  st_op_next;
  logic        take_status, take_data, take_bff, ser_load, ser_busy;
  resp_kind_t  ser_kind;
  logic [PAY_W-1:0] ser_payload;

  assign hdr_shift = {hdr_sr_reg[15:0], rx_data};
  assign hdr_hit   = rx_valid && (hdr_shift == {CH_TILDE, CH_ONE, CH_UNDER});
  assign last_byte = rx_valid && !hdr_hit && (idx_reg == IDX_W'(ADR_BYTES + 1));
  assign tmo_hit   = (pstate_reg == P_PAYLOAD) && !rx_valid && (tmo_reg == TMO_W'(TIMEOUT_CLKS));
  assign chk_run   = (pstate_reg == P_CHECK);
  assign chk_accept = chk_run && csum_ok_reg && is_known(op_reg) && !cmd_valid_reg;
  assign handshake = cmd_valid_reg && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) pstate_reg <= P_HUNT;
    else     pstate_reg <= pstate_next;
  end

  always_comb begin
    pstate_next = pstate_reg;
    case (pstate_reg)
      P_HUNT:    if (hdr_hit) pstate_next = P_PAYLOAD;
      P_PAYLOAD: begin
        if (tmo_hit)        pstate_next = P_HUNT;
        else if (last_byte) pstate_next = P_CHECK;
      end
      P_CHECK:   pstate_next = hdr_hit ? P_PAYLOAD : P_HUNT;
      default:   pstate_next = P_HUNT;
    endcase
  end

  // Byte 0 is the opcode, then address bytes, then the checksum byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_sr_reg  <= '0;
      idx_reg     <= '0;
      sum_reg     <= '0;
      op_reg      <= '0;
      adr_reg     <= '0;
      csum_ok_reg <= 1'b0;
      tmo_reg     <= '0;
    end else begin
      if (rx_valid) hdr_sr_reg <= hdr_shift;
      if (hdr_hit) begin
        idx_reg <= '0;
        sum_reg <= '0;
        tmo_reg <= '0;
      end else if (pstate_reg == P_PAYLOAD && rx_valid) begin
        idx_reg <= idx_reg + IDX_W'(1);
        tmo_reg <= '0;
        if (idx_reg == '0) begin
          op_reg  <= rx_data;
          sum_reg <= sum_reg + rx_data;
        end else if (idx_reg <= IDX_W'(ADR_BYTES)) begin
          adr_reg <= (adr_reg << 8) | ADR_W'(rx_data);
          sum_reg <= sum_reg + rx_data;
        end else begin
          csum_ok_reg <= (rx_data == sum_reg);
        end
      end else if (pstate_reg == P_PAYLOAD) begin
        tmo_reg <= tmo_reg + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_reg <= 1'b0;
      cmd_op_reg    <= '0;
      cmd_adr_reg   <= '0;
    end else if (chk_accept) begin
      cmd_valid_reg <= 1'b1;
      cmd_op_reg    <= op_reg;
      cmd_adr_reg   <= adr_reg;
    end else if (handshake) begin
      cmd_valid_reg <= 1'b0;
    end
  end

  // Parser outcomes take precedence over an OK ack raised in the same cycle.
  always_comb begin
    st_set       = 1'b0;
    st_code_next = ST_OK;
    st_op_next   = cmd_op_reg;
    if (handshake && is_acked(cmd_op_reg)) st_set = 1'b1;
    if (tmo_hit) begin
      st_set       = 1'b1;
      st_code_next = ST_TIMEOUT;
      st_op_next   = op_reg;
    end else if (chk_run && !chk_accept) begin
      st_set     = 1'b1;
      st_op_next = op_reg;
      if (!csum_ok_reg)           st_code_next = ST_CRC;
      else if (!is_known(op_reg)) st_code_next = ST_UNKNOWN;
      else                        st_code_next = ST_BUSY;
    end
  end

  always_comb begin
    take_status = 1'b0;
    take_data   = 1'b0;
    take_bff    = 1'b0;
    ser_kind    = RESP_STATUS;
    ser_payload = PAY_W'({st_code_reg, st_op_reg});
    if (!ser_busy) begin
      if (st_pend_reg) begin
        take_status = 1'b1;
      end else if (data_pend_reg) begin
        take_data   = 1'b1;
        ser_kind    = RESP_DATA;
        ser_payload = PAY_W'(data_reg);
      end else if (bff_pend_reg) begin
        take_bff = 1'b1;
        ser_kind = RESP_BFF;
      end
    end
  end
  assign ser_load = take_status | take_data | take_bff;

  // New events win over a same-cycle take so nothing is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_pend_reg   <= 1'b0;
      st_code_reg   <= ST_OK;
      st_op_reg     <= '0;
      data_pend_reg <= 1'b0;
      data_reg      <= '0;
      bff_pend_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (st_set) begin
        st_pend_reg <= 1'b1;
        st_code_reg <= st_code_next;
        st_op_reg   <= st_op_next;
      end else if (take_status) begin
        st_pend_reg <= 1'b0;
      end
      if (rd_valid) begin
        data_pend_reg <= 1'b1;
        data_reg      <= rd_data;
        if (data_pend_reg && !take_data) overrun_reg <= 1'b1;
      end else if (take_data) begin
        data_pend_reg <= 1'b0;
      end
      if (bff)           bff_pend_reg <= 1'b1;
      else if (take_bff) bff_pend_reg <= 1'b0;
    end
  end

  uart_resp_serializer #(.DATA_BYTES(DATA_BYTES)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .kind     (ser_kind),
    .payload  (ser_payload),
    .busy     (ser_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  assign cmd_valid = cmd_valid_reg;
  assign cmd_op    = cmd_op_reg;
  assign cmd_adr   = cmd_adr_reg;
  assign pause     = ser_busy;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_flash_uart_cmd_ctrl.sv
// Directed bench for flash_uart_cmd_ctrl: frames in, handshake and transmitted
// response bytes checked against hand-computed values.
module tb_flash_uart_cmd_ctrl;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_adr;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        bff = 1'b0;
  logic        pause;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  int busy_cnt = 0;

  flash_uart_cmd_ctrl #(.ADR_BYTES(3), .DATA_BYTES(4), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .rd_valid(rd_valid), .rd_data(rd_data), .bff(bff),
    .pause(pause), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Transmitter model: capture each started byte and stay busy for 3 cycles.
  always @(negedge clk) begin
    if (tx_start) begin
      tx_q.push_back(tx_data);
      $display("tx byte %02h", tx_data);
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    tx_busy = (busy_cnt != 0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [23:0] adr, input logic [7:0] cs);
    logic [63:0] f;
    f = {8'h7E, 8'h31, 8'h5F, op, adr, cs};
    for (int i = 7; i >= 0; i--) send_byte(f[8*i +: 8]);
  endtask

  task automatic do_handshake;
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0;
  endtask

  task automatic rd_pulse(input logic [31:0] d, input logic with_bff);
    @(posedge clk); #1;
    rd_data = d; rd_valid = 1'b1; bff = with_bff;
    @(posedge clk); #1;
    rd_valid = 1'b0; bff = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input int n, input logic [63:0] exp);
    logic [63:0] got;
    int cyc;
    got = '0;
    cyc = 0;
    while (tx_q.size() < n && cyc < 600) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    for (int i = 0; i < n; i++)
      if (tx_q.size() > 0) got = {got[55:0], tx_q.pop_front()};
    check(tag, got, exp);
  endtask

  initial begin
    tick(3);
    check("rst_tx", {55'd0, tx_start, tx_data}, 64'd0);
    check("rst_cmd", {31'd0, cmd_valid, cmd_op, cmd_adr}, 64'd0);
    check("rst_pause", {63'd0, pause}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
    rst = 1'b0;
    tick(2);

    // Acked C7, with cycle-exact cmd_valid latency and pause timing.
    send_frame(8'hC7, 24'h000000, 8'hC7);
    check("c7_check_cycle_valid", {63'd0, cmd_valid}, 64'd0);
    tick(1);
    check("c7_valid", {63'd0, cmd_valid}, 64'd1);
    check("c7_cmd", {32'd0, cmd_op, cmd_adr}, {32'd0, 8'hC7, 24'h000000});
    tick(10);
    check("c7_no_ack_before_ready", tx_q.size(), 0);
    do_handshake();
    check("c7_valid_drop", {63'd0, cmd_valid}, 64'd0);
    tick(1);
    check("c7_pause_rise", {63'd0, pause}, 64'd1);
    expect_resp("c7_ack", 6, 64'h7E615F00C70D);
    check("c7_pause_fall", {63'd0, pause}, 64'd0);

    send_frame(8'h81, 24'h001234, 8'hC7);
    tick(1);
    check("81_cmd", {31'd0, cmd_valid, cmd_op, cmd_adr}, {31'd0, 1'b1, 8'h81, 24'h001234});
    do_handshake();
    expect_resp("81_ack", 6, 64'h7E615F00810D);

    send_frame(8'hC7, 24'h000000, 8'h00);
    tick(1);
    check("crc_no_valid", {63'd0, cmd_valid}, 64'd0);
    expect_resp("crc_status", 6, 64'h7E615F01C70D);

    send_frame(8'h55, 24'h000000, 8'h55);
    expect_resp("unknown_status", 6, 64'h7E615F02550D);

    send_frame(8'h9F, 24'h000000, 8'h9F);
    tick(1);
    check("9f_cmd", {55'd0, cmd_valid, cmd_op}, {55'd0, 1'b1, 8'h9F});
    do_handshake();
    tick(40);
    check("9f_silent", {31'd0, pause, tx_q.size()}, 64'd0);

    // Second frame while the first is still pending gets BUSY.
    send_frame(8'h81, 24'h001234, 8'hC7);
    send_frame(8'h84, 24'h000056, 8'hDA);
    expect_resp("busy_status", 6, 64'h7E615F04840D);
    check("busy_keeps_cmd", {31'd0, cmd_valid, cmd_op, cmd_adr}, {31'd0, 1'b1, 8'h81, 24'h001234});
    do_handshake();
    expect_resp("busy_then_ack", 6, 64'h7E615F00810D);

    // Read data, then overrun while the first response is on the wire.
    rd_pulse(32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 50 && !pause; i++) tick(1);
    check("rd_pause", {63'd0, pause}, 64'd1);
    rd_pulse(32'h11111111, 1'b0);
    check("rd_no_overrun_yet", {63'd0, overrun}, 64'd0);
    rd_pulse(32'h22222222, 1'b0);
    check("rd_overrun", {63'd0, overrun}, 64'd1);
    expect_resp("rd_first", 8, 64'h7E6B5FDEADBEEF0D);
    expect_resp("rd_third", 8, 64'h7E6B5F222222220D);

    rd_pulse(32'hCAFEF00D, 1'b1);
    expect_resp("both_data", 8, 64'h7E6B5FCAFEF00D0D);
    expect_resp("both_bff", 4, 64'h7E665F0D);

    // Timeout: no status before TMO+1 silent cycles, status 03 after.
    send_byte(8'h7E); send_byte(8'h31); send_byte(8'h5F);
    send_byte(8'hC7); send_byte(8'h00);
    tick(TMO);
    check("tmo_not_early", {31'd0, pause, tx_q.size()}, 64'd0);
    expect_resp("tmo_status", 6, 64'h7E615F03C70D);

    // Reset in the middle of a response.
    rd_pulse(32'h0, 1'b1);
    for (int i = 0; i < 100 && tx_q.size() < 2; i++) tick(1);
    check("mid_resp_started", {63'd0, pause}, 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    tick(1);
    check("rst_mid_tx", {62'd0, pause, tx_start}, 64'd0);
    check("rst_mid_overrun", {63'd0, overrun}, 64'd0);
    rst = 1'b0;
    tick(30);
    check("rst_mid_quiet", {63'd0, pause}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
